// File: rtl/serial_bus_arbiter.sv
// Round-robin arbiter sharing one serial link: 8-bit address out, 8-bit data in.
module serial_bus_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned HALF = 2
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic [NREQ-1:0]     REQ,
    input  logic [8*NREQ-1:0]   ADDR_IN,
    output logic [NREQ-1:0]     GNT,
    output logic                BUSY,
    output logic                DONE,
    output logic [7:0]          RD_DATA,
    output logic                TX,
    output logic                SCLK,
    input  logic                RX
);

    localparam int unsigned LW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned DW = (HALF > 1) ? $clog2(HALF) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_DONE
    } state_t;

    state_t          r_state, w_state;
    logic [DW-1:0]   r_div, w_div;
    logic [2:0]      r_bit, w_bit;
    logic            r_phase, w_phase;     // 0: SCLK low phase, 1: SCLK high phase
    logic [7:0]      r_addr, w_addr;
    logic [6:0]      r_shift, w_shift;     // data bits 0..6; bit 7 goes straight to RD_DATA
    logic [NREQ-1:0] r_gnt, w_gnt;
    logic            r_busy, w_busy;
    logic            r_done, w_done;
    logic [7:0]      r_rd, w_rd;
    logic            r_tx, w_tx;
    logic            r_sclk, w_sclk;
    logic [LW-1:0]   r_last, w_last;

    logic            w_found;
    logic [LW-1:0]   w_win;
    logic [7:0]      w_sel_addr;

    // Round-robin search starting just after the last winner
    always_comb begin
        w_found = 1'b0;
        w_win   = r_last;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            if (!w_found && REQ[LW'((32'(r_last) + i) % NREQ)]) begin
                w_found = 1'b1;
                w_win   = LW'((32'(r_last) + i) % NREQ);
            end
        end
        w_sel_addr = ADDR_IN[{w_win, 3'b000} +: 8];
    end

    // Next-state and next-output logic
    always_comb begin
        w_state = r_state;
        w_div   = r_div;
        w_bit   = r_bit;
        w_phase = r_phase;
        w_addr  = r_addr;
        w_shift = r_shift;
        w_gnt   = r_gnt;
        w_busy  = r_busy;
        w_done  = 1'b0;
        w_rd    = r_rd;
        w_tx    = r_tx;
        w_sclk  = r_sclk;
        w_last  = r_last;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state = S_ADDR;
                    w_addr  = w_sel_addr;
                    w_gnt   = NREQ'(1) << w_win;
                    w_busy  = 1'b1;
                    w_last  = w_win;
                    w_div   = '0;
                    w_bit   = 3'd0;
                    w_phase = 1'b0;
                    w_sclk  = 1'b0;
                    w_tx    = w_sel_addr[0];
                end
            end
            S_ADDR, S_DATA: begin
                if (r_div != DW'(HALF - 1)) begin
                    w_div = r_div + DW'(1);
                end else begin
                    w_div = '0;
                    if (!r_phase) begin
                        w_phase = 1'b1;
                        w_sclk  = 1'b1;
                    end else if (r_bit == 3'd7) begin
                        // Last bit of this byte: move to the next section
                        w_bit   = 3'd0;
                        w_phase = 1'b0;
                        w_tx    = 1'b0;
                        if (r_state == S_ADDR) begin
                            w_state = S_DATA;
                            w_sclk  = 1'b0;
                        end else begin
                            w_state = S_DONE;
                            w_done  = 1'b1;
                            w_rd    = {RX, r_shift};
                        end
                    end else begin
                        if (r_state == S_DATA) begin
                            w_shift[r_bit] = RX;
                        end
                        w_bit   = r_bit + 3'd1;
                        w_phase = 1'b0;
                        w_sclk  = 1'b0;
                        w_tx    = (r_state == S_ADDR) ? r_addr[3'(r_bit + 3'd1)] : 1'b0;
                    end
                end
            end
            S_DONE: begin
                w_state = S_IDLE;
                w_gnt   = '0;
                w_busy  = 1'b0;
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= S_IDLE;
            r_div   <= '0;
            r_bit   <= 3'd0;
            r_phase <= 1'b0;
            r_addr  <= 8'd0;
            r_shift <= 7'd0;
            r_gnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_rd    <= 8'd0;
            r_tx    <= 1'b0;
            r_sclk  <= 1'b1;
            r_last  <= LW'(NREQ - 1);
        end else begin
            r_state <= w_state;
            r_div   <= w_div;
            r_bit   <= w_bit;
            r_phase <= w_phase;
            r_addr  <= w_addr;
            r_shift <= w_shift;
            r_gnt   <= w_gnt;
            r_busy  <= w_busy;
            r_done  <= w_done;
            r_rd    <= w_rd;
            r_tx    <= w_tx;
            r_sclk  <= w_sclk;
            r_last  <= w_last;
        end
    end

    assign GNT     = r_gnt;
    assign BUSY    = r_busy;
    assign DONE    = r_done;
    assign RD_DATA = r_rd;
    assign TX      = r_tx;
    assign SCLK    = r_sclk;

endmodule
